cmp_stim_checker: RTL and testbench

- Self-checking driver/checker for the 1-bit magnitude comparator interface; it is the opposite end of the A/B -> C1/C2/C3 link.
- On start, it sweeps all four {A,B} vectors, lets the comparator settle, and samples the comparator outputs.
- Each sample is checked against the golden one-hot result, then the block reports an error count, the first failing vector, and a pass flag.
- Used in on-chip self-test and in system benches in place of hand-written stimulus.

---
 rtl/cmp_stim_checker.sv | 138 +++++++++++++
 tb/tb_cmp_stim_checker.sv | 214 +++++++++++++++++++++
 2 files changed

// File: rtl/cmp_stim_checker.sv
// Sweeps {A,B} over 00..11 for N_PASSES passes and checks C1..C3 against the golden one-hot compare.
// Each vector takes SETTLE+1 cycles. A start that arrives while a run is in progress is ignored.
module cmp_stim_checker #(
  parameter int unsigned N_PASSES = 1,
  parameter int unsigned SETTLE   = 1,
  parameter int unsigned ERR_W    = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  output logic             A,
  output logic             B,
  input  logic             C1,
  input  logic             C2,
  input  logic             C3,
  output logic             busy,
  output logic             done,
  output logic             pass,
  output logic [ERR_W-1:0] err_cnt,
  output logic             fail_valid,
  output logic [1:0]       fail_vec
);

  localparam int unsigned PW = (N_PASSES > 1) ? $clog2(N_PASSES) : 1;
  localparam int unsigned WW = (SETTLE > 1) ? $clog2(SETTLE) : 1;
  localparam logic [PW-1:0]    LAST_PASS = PW'(N_PASSES - 1);
  localparam logic [WW-1:0]    LAST_WAIT = WW'(SETTLE - 1);
  localparam logic [ERR_W-1:0] ERR_MAX   = '1;

  typedef enum logic [1:0] {S_IDLE, S_SETTLE, S_CHECK, S_DONE} state_t;

  state_t         state, state_nxt;
  logic [1:0]     vec;
  logic [PW-1:0]  pass_cnt;
  logic [WW-1:0]  wait_cnt;
  logic [2:0]     exp_c;
  logic [2:0]     got_c;
  logic           mismatch;
  logic           last_vec;

  always_comb begin
    exp_c = 3'b010;
    case (vec)
      2'd0:    exp_c = 3'b010;
      2'd1:    exp_c = 3'b001;
      2'd2:    exp_c = 3'b100;
      default: exp_c = 3'b010;
    endcase
  end

  // Full 3-bit compare, so multi-hot or all-zero responses are errors too.
  assign got_c    = {C1, C2, C3};
  assign mismatch = (got_c != exp_c);
  assign last_vec = (vec == 2'd3) && (pass_cnt == LAST_PASS);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= S_IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    busy      = 1'b0;
    done      = 1'b0;
    case (state)
      S_IDLE: begin
        if (start) state_nxt = S_SETTLE;
      end
      S_SETTLE: begin
        busy = 1'b1;
        if (wait_cnt == LAST_WAIT) state_nxt = S_CHECK;
      end
      S_CHECK: begin
        busy      = 1'b1;
        state_nxt = last_vec ? S_DONE : S_SETTLE;
      end
      default: begin
        done      = 1'b1;
        state_nxt = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      A          <= 1'b0;
      B          <= 1'b0;
      vec        <= 2'd0;
      pass_cnt   <= '0;
      wait_cnt   <= '0;
      err_cnt    <= '0;
      fail_valid <= 1'b0;
      fail_vec   <= 2'd0;
      pass       <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          if (start) begin
            A          <= 1'b0;
            B          <= 1'b0;
            vec        <= 2'd0;
            pass_cnt   <= '0;
            wait_cnt   <= '0;
            err_cnt    <= '0;
            fail_valid <= 1'b0;
            fail_vec   <= 2'd0;
            pass       <= 1'b0;
          end
        end
        S_SETTLE: begin
          wait_cnt <= wait_cnt + WW'(1);
        end
        S_CHECK: begin
          if (mismatch) begin
            if (err_cnt != ERR_MAX) err_cnt <= err_cnt + ERR_W'(1);
            if (!fail_valid) begin
              fail_valid <= 1'b1;
              fail_vec   <= vec;
            end
          end
          if (last_vec) begin
            A    <= 1'b0;
            B    <= 1'b0;
            // Final verdict lands with done, folding in this last sample.
            pass <= (err_cnt == '0) && !mismatch;
          end else begin
            {A, B}   <= vec + 2'd1;
            vec      <= vec + 2'd1;
            wait_cnt <= '0;
            if (vec == 2'd3) pass_cnt <= pass_cnt + PW'(1);
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_cmp_stim_checker.sv
// Drives three checker instances against behavioural comparator models and scoreboards run results.
module tb_cmp_stim_checker;

  logic       clk;
  logic       rst_n;
  logic [2:0] start_r;
  int         mode;
  int         errs;
  int         checks;

  logic       a0, b0, a1, b1, a2, b2;
  logic [2:0] c0, c1, c2;
  logic [2:0] busy_a, done_a, pass_a, fv_a;
  logic [7:0] e0, e1;
  logic [1:0] e2;
  logic [1:0] fvec_a [3];
  logic [1:0] ab_a [3];
  logic [31:0] err_a [3];

  typedef struct {
    int err;
    int pss;
    int fv;
    int fvec;
  } res_t;
  res_t sb[$];

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Instance 0 model is selectable: 0 correct, 1 C1/C3 swapped, 2 stuck at 000.
  always_comb begin
    c0 = {a0 > b0, a0 == b0, a0 < b0};
    if (mode == 1) c0 = {a0 < b0, a0 == b0, a0 > b0};
    else if (mode == 2) c0 = 3'b000;
  end
  assign c1 = {a1 > b1, a1 == b1, a1 < b1};
  assign c2 = 3'b111;

  cmp_stim_checker dut0 (
    .clk(clk), .rst_n(rst_n), .start(start_r[0]), .A(a0), .B(b0),
    .C1(c0[2]), .C2(c0[1]), .C3(c0[0]), .busy(busy_a[0]), .done(done_a[0]),
    .pass(pass_a[0]), .err_cnt(e0), .fail_valid(fv_a[0]), .fail_vec(fvec_a[0])
  );

  cmp_stim_checker #(.N_PASSES(3), .SETTLE(2)) dut1 (
    .clk(clk), .rst_n(rst_n), .start(start_r[1]), .A(a1), .B(b1),
    .C1(c1[2]), .C2(c1[1]), .C3(c1[0]), .busy(busy_a[1]), .done(done_a[1]),
    .pass(pass_a[1]), .err_cnt(e1), .fail_valid(fv_a[1]), .fail_vec(fvec_a[1])
  );

  cmp_stim_checker #(.N_PASSES(2), .SETTLE(1), .ERR_W(2)) dut2 (
    .clk(clk), .rst_n(rst_n), .start(start_r[2]), .A(a2), .B(b2),
    .C1(c2[2]), .C2(c2[1]), .C3(c2[0]), .busy(busy_a[2]), .done(done_a[2]),
    .pass(pass_a[2]), .err_cnt(e2), .fail_valid(fv_a[2]), .fail_vec(fvec_a[2])
  );

  assign ab_a[0]  = {a0, b0};
  assign ab_a[1]  = {a1, b1};
  assign ab_a[2]  = {a2, b2};
  assign err_a[0] = 32'(e0);
  assign err_a[1] = 32'(e1);
  assign err_a[2] = 32'(e2);

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errs++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  function automatic logic [2:0] golden(input int v);
    case (v)
      0:       golden = 3'b010;
      1:       golden = 3'b001;
      2:       golden = 3'b100;
      default: golden = 3'b010;
    endcase
  endfunction

  function automatic logic [2:0] model(input int i, input int v);
    logic [1:0] ab;
    ab = 2'(v);
    if (i == 2) model = 3'b111;
    else if (i == 0 && mode == 2) model = 3'b000;
    else if (i == 0 && mode == 1) model = {ab[1] < ab[0], ab[1] == ab[0], ab[1] > ab[0]};
    else model = {ab[1] > ab[0], ab[1] == ab[0], ab[1] < ab[0]};
  endfunction

  // One full run on instance i; rp is the cycle at which a stray start is injected (-1 = none).
  task automatic run(input int i, input int np, input int s, input int emax, input int rp);
    res_t e;
    res_t g;
    int   total;
    total = 4 * np * (s + 1);
    e = '{err: 0, pss: 0, fv: 0, fvec: 0};
    for (int p = 0; p < np; p++)
      for (int v = 0; v < 4; v++)
        if (model(i, v) !== golden(v)) begin
          if (e.err < emax) e.err++;
          if (e.fv == 0) begin
            e.fv   = 1;
            e.fvec = v;
          end
        end
    e.pss = (e.err == 0) ? 1 : 0;
    @(negedge clk);
    start_r[i] = 1'b1;
    sb.push_back(e);
    @(posedge clk);
    #1;
    start_r[i] = 1'b0;
    chk($sformatf("u%0d busy_at_accept", i), 32'(busy_a[i]), 1);
    chk($sformatf("u%0d ab_at_accept", i), 32'(ab_a[i]), 0);
    for (int k = 1; k <= total; k++) begin
      start_r[i] = (k == rp);
      @(posedge clk);
      #1;
      start_r[i] = 1'b0;
      chk($sformatf("u%0d done_k%0d", i, k), 32'(done_a[i]), (k == total) ? 1 : 0);
      if (k < total)
        chk($sformatf("u%0d ab_k%0d", i, k), 32'(ab_a[i]), (k / (s + 1)) % 4);
      else
        chk($sformatf("u%0d ab_end", i), 32'(ab_a[i]), 0);
    end
    g = sb.pop_front();
    chk($sformatf("u%0d busy_end", i), 32'(busy_a[i]), 0);
    chk($sformatf("u%0d err_cnt", i), err_a[i], g.err);
    chk($sformatf("u%0d pass", i), 32'(pass_a[i]), g.pss);
    chk($sformatf("u%0d fail_valid", i), 32'(fv_a[i]), g.fv);
    chk($sformatf("u%0d fail_vec", i), 32'(fvec_a[i]), g.fvec);
    @(posedge clk);
    #1;
    chk($sformatf("u%0d done_drop", i), 32'(done_a[i]), 0);
    chk($sformatf("u%0d pass_held", i), 32'(pass_a[i]), g.pss);
    chk($sformatf("u%0d err_held", i), err_a[i], g.err);
  endtask

  task automatic chk_zero0(input string tag);
    chk({tag, "_ab"}, 32'(ab_a[0]), 0);
    chk({tag, "_busy"}, 32'(busy_a[0]), 0);
    chk({tag, "_done"}, 32'(done_a[0]), 0);
    chk({tag, "_pass"}, 32'(pass_a[0]), 0);
    chk({tag, "_err"}, err_a[0], 0);
    chk({tag, "_fv"}, 32'(fv_a[0]), 0);
    chk({tag, "_fvec"}, 32'(fvec_a[0]), 0);
  endtask

  initial begin
    errs    = 0;
    checks  = 0;
    mode    = 0;
    start_r = 3'b000;
    rst_n   = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk_zero0("reset");
    chk("reset_u2_err", err_a[2], 0);
    @(negedge clk);
    rst_n = 1'b1;

    mode = 0; run(0, 1, 1, 255, -1);
    mode = 1; run(0, 1, 1, 255, -1);
    mode = 2; run(0, 1, 1, 255, -1);
    mode = 0; run(0, 1, 1, 255, 3);
    run(1, 3, 2, 255, -1);
    run(2, 2, 1, 3, -1);

    // Start held high: done at 8, one IDLE cycle, next run accepted at edge 10.
    mode = 0;
    @(negedge clk);
    start_r[0] = 1'b1;
    @(posedge clk);
    #1;
    for (int k = 1; k <= 10; k++) begin
      @(posedge clk);
      #1;
      if (k == 8) begin
        chk("hold_done8", 32'(done_a[0]), 1);
        mode = 1;
      end
      if (k == 9) chk("hold_gap_busy", 32'(busy_a[0]), 0);
      if (k == 10) begin
        chk("hold_restart_busy", 32'(busy_a[0]), 1);
        chk("hold_restart_ab", 32'(ab_a[0]), 0);
      end
    end
    start_r[0] = 1'b0;
    repeat (5) @(posedge clk);
    #1;
    chk("midrun_err", err_a[0], 1);
    chk("midrun_fvec", 32'(fvec_a[0]), 1);
    #2;
    rst_n = 1'b0;
    #1;
    chk_zero0("async_rst");
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    for (int k = 0; k < 6; k++) begin
      @(posedge clk);
      #1;
      chk($sformatf("post_rst_done%0d", k), 32'(done_a[0]), 0);
    end
    mode = 0;
    run(0, 1, 1, 255, -1);

    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end

endmodule
